// File: rtl/bp_be_dcache_req_encoder_pkg.sv
// Purpose: shared types and helpers for the LSU-side D$ request encoder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: opcode enum, access-size enum, decoded LSU request struct, encode/check/replicate functions.
package bp_be_dcache_req_encoder_pkg;

  localparam int vaddr_width_gp       = 39;
  localparam int page_offset_width_gp = 12;
  localparam int dword_width_gp       = 64;
  localparam int opcode_width_gp      = 4;

  typedef enum logic [3:0] {
    e_dcache_op_lb  = 4'b0000,
    e_dcache_op_lh  = 4'b0001,
    e_dcache_op_lw  = 4'b0010,
    e_dcache_op_ld  = 4'b0011,
    e_dcache_op_lbu = 4'b0100,
    e_dcache_op_lhu = 4'b0101,
    e_dcache_op_lwu = 4'b0110,
    e_dcache_op_lrw = 4'b0111,
    e_dcache_op_sb  = 4'b1000,
    e_dcache_op_sh  = 4'b1001,
    e_dcache_op_sw  = 4'b1010,
    e_dcache_op_sd  = 4'b1011,
    e_dcache_op_scw = 4'b1100,
    e_dcache_op_lrd = 4'b1101,
    e_dcache_op_scd = 4'b1110
  } bp_be_dcache_opcode_e;

  typedef enum logic [1:0] {
    e_size_b = 2'd0,
    e_size_h = 2'd1,
    e_size_w = 2'd2,
    e_size_d = 2'd3
  } bp_be_dcache_size_e;

  typedef struct packed {
    logic                      store;
    logic                      sign_ext;
    bp_be_dcache_size_e        size;
    logic                      lr;
    logic                      sc;
    logic [vaddr_width_gp-1:0] vaddr;
    logic [dword_width_gp-1:0] data;
  } bp_be_dcache_lsu_req_s;

  // SC/LR take priority over plain store/load; an unsigned D load has no
  // zero-extending variant, so it maps onto ld.
  function automatic bp_be_dcache_opcode_e encode_opcode(input bp_be_dcache_lsu_req_s req);
    bp_be_dcache_opcode_e op;
    op = e_dcache_op_ld;
    if (req.sc) begin
      op = (req.size == e_size_d) ? e_dcache_op_scd : e_dcache_op_scw;
    end else if (req.lr) begin
      op = (req.size == e_size_d) ? e_dcache_op_lrd : e_dcache_op_lrw;
    end else if (req.store) begin
      case (req.size)
        e_size_b: op = e_dcache_op_sb;
        e_size_h: op = e_dcache_op_sh;
        e_size_w: op = e_dcache_op_sw;
        default:  op = e_dcache_op_sd;
      endcase
    end else if (req.sign_ext) begin
      case (req.size)
        e_size_b: op = e_dcache_op_lb;
        e_size_h: op = e_dcache_op_lh;
        e_size_w: op = e_dcache_op_lw;
        default:  op = e_dcache_op_ld;
      endcase
    end else begin
      case (req.size)
        e_size_b: op = e_dcache_op_lbu;
        e_size_h: op = e_dcache_op_lhu;
        e_size_w: op = e_dcache_op_lwu;
        default:  op = e_dcache_op_ld;
      endcase
    end
    return op;
  endfunction

  function automatic logic is_illegal(input bp_be_dcache_lsu_req_s req);
    return (req.lr & req.sc)
         | (req.lr & req.store)
         | (req.sc & ~req.store)
         | ((req.lr | req.sc) & ((req.size == e_size_b) | (req.size == e_size_h)));
  endfunction

  function automatic logic is_misaligned(input bp_be_dcache_lsu_req_s req);
    logic mis;
    case (req.size)
      e_size_h: mis = req.vaddr[0];
      e_size_w: mis = |req.vaddr[1:0];
      e_size_d: mis = |req.vaddr[2:0];
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Replicate the low bytes across the dword so the D$ can pick byte lanes
  // by page offset without a shifter.
  function automatic logic [dword_width_gp-1:0] replicate_data(input bp_be_dcache_size_e size,
                                                               input logic [dword_width_gp-1:0] data);
    logic [dword_width_gp-1:0] rep;
    case (size)
      e_size_b: rep = {8{data[7:0]}};
      e_size_h: rep = {4{data[15:0]}};
      e_size_w: rep = {2{data[31:0]}};
      default:  rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/bp_be_dcache_req_encoder_if.sv
// Purpose: bundles the LSU request side, D$ packet side, SC completion, flush and exception outputs.
// Latency: n/a (wiring only).
// Backpressure: lsu_ready_o toward the pipe, dcache_pkt_ready_i from the D$.
// Modports: slave = encoder view, master = environment (pipe + D$) view.
interface bp_be_dcache_req_encoder_if #(
  parameter int vaddr_width_p       = 39,
  parameter int page_offset_width_p = 12,
  parameter int dword_width_p       = 64
);
  localparam int pkt_width_lp = 4 + page_offset_width_p + dword_width_p;

  logic                     flush_i;
  logic                     lsu_v_i;
  logic                     lsu_ready_o;
  logic                     lsu_store_i;
  logic                     lsu_signed_i;
  logic [1:0]               lsu_size_i;
  logic                     lsu_lr_i;
  logic                     lsu_sc_i;
  logic [vaddr_width_p-1:0] lsu_vaddr_i;
  logic [dword_width_p-1:0] lsu_data_i;
  logic                     dcache_pkt_v_o;
  logic                     dcache_pkt_ready_i;
  logic [pkt_width_lp-1:0]  dcache_pkt_o;
  logic                     sc_done_i;
  logic                     misalign_v_o;
  logic                     illegal_v_o;
  logic [vaddr_width_p-1:0] exc_vaddr_o;

  modport slave (
    input  flush_i, lsu_v_i, lsu_store_i, lsu_signed_i, lsu_size_i, lsu_lr_i, lsu_sc_i,
           lsu_vaddr_i, lsu_data_i, dcache_pkt_ready_i, sc_done_i,
    output lsu_ready_o, dcache_pkt_v_o, dcache_pkt_o, misalign_v_o, illegal_v_o, exc_vaddr_o
  );

  modport master (
    output flush_i, lsu_v_i, lsu_store_i, lsu_signed_i, lsu_size_i, lsu_lr_i, lsu_sc_i,
           lsu_vaddr_i, lsu_data_i, dcache_pkt_ready_i, sc_done_i,
    input  lsu_ready_o, dcache_pkt_v_o, dcache_pkt_o, misalign_v_o, illegal_v_o, exc_vaddr_o
  );

endinterface

// File: rtl/bp_be_dcache_req_fifo.sv
// Purpose: 2-entry packet queue between the encoder and the D$ packet port.
// Latency: 1 cycle from enqueue to v_o.
// Backpressure: ready_o low when both entries are occupied; clear_i empties the queue at the edge.
// Ports: clk_i, reset_n_i, clear_i; v_i/ready_o/data_i in; v_o/ready_i/data_o out.
module bp_be_dcache_req_fifo #(
  parameter int width_p = 80
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic               enq;
  logic               deq;

  assign ready_o = (count != 2'd2);
  assign v_o     = (count != 2'd0);
  assign data_o  = mem[rd_ptr];
  assign enq     = v_i & ready_o;
  assign deq     = v_o & ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_be_dcache_req_encoder.sv
// Purpose: encodes decoded LSU memory requests into D$ packets {opcode, page_offset, data}.
// Latency: 1 cycle from accepted request to dcache_pkt_v_o; exception pulses 1 cycle after accept.
// Backpressure: lsu_ready_o low when the queue is full, an SC result is outstanding, or flush_i.
// Ports: clk_i, reset_n_i (async active-low), io (bp_be_dcache_req_encoder_if.slave).
// Build option: BP_BE_DCACHE_REQ_MISALIGN_CHECK_EN enables the alignment check; without it
// misaligned requests are issued unchanged and misalign_v_o stays 0.
module bp_be_dcache_req_encoder
  import bp_be_dcache_req_encoder_pkg::*;
#(
  parameter int vaddr_width_p       = 39,
  parameter int page_offset_width_p = 12,
  parameter int dword_width_p       = 64
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bp_be_dcache_req_encoder_if.slave io
);

  localparam int pkt_width_lp = 4 + page_offset_width_p + dword_width_p;

  bp_be_dcache_lsu_req_s    req;
  logic                     illegal;
  logic                     misalign;
  logic                     accept;
  logic                     enq;
  logic [3:0]               opcode;
  logic [pkt_width_lp-1:0]  fifo_data_li;
  logic [pkt_width_lp-1:0]  fifo_data_lo;
  logic                     fifo_ready;
  logic                     fifo_v;
  logic                     sc_pending_q;
  logic                     illegal_q;
  logic                     misalign_q;
  logic [vaddr_width_p-1:0] exc_vaddr_q;

  always_comb begin
    req          = '0;
    req.store    = io.lsu_store_i;
    req.sign_ext = io.lsu_signed_i;
    req.size     = bp_be_dcache_size_e'(io.lsu_size_i);
    req.lr       = io.lsu_lr_i;
    req.sc       = io.lsu_sc_i;
    req.vaddr    = io.lsu_vaddr_i;
    req.data     = io.lsu_data_i;
  end

  assign illegal = is_illegal(req);

`ifdef BP_BE_DCACHE_REQ_MISALIGN_CHECK_EN
  // An illegal request reports only the illegal pulse.
  assign misalign = is_misaligned(req) & ~illegal;
`else
  assign misalign = 1'b0;
`endif

  // Ready is forced low in reset so nothing is accepted before the queue is live.
  assign io.lsu_ready_o = reset_n_i & fifo_ready & ~sc_pending_q & ~io.flush_i;
  assign accept         = io.lsu_v_i & io.lsu_ready_o;
  assign enq            = accept & ~illegal & ~misalign;

  assign opcode       = encode_opcode(req);
  assign fifo_data_li = {opcode,
                         req.vaddr[page_offset_width_p-1:0],
                         replicate_data(req.size, req.data)};

  bp_be_dcache_req_fifo #(
    .width_p(pkt_width_lp)
  ) req_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (io.flush_i),
    .v_i      (enq),
    .ready_o  (fifo_ready),
    .data_i   (fifo_data_li),
    .v_o      (fifo_v),
    .ready_i  (io.dcache_pkt_ready_i),
    .data_o   (fifo_data_lo)
  );

  // Set has priority over sc_done_i; a stray sc_done_i with nothing pending is a no-op.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sc_pending_q <= 1'b0;
    end else if (io.flush_i) begin
      sc_pending_q <= 1'b0;
    end else if (enq & req.sc) begin
      sc_pending_q <= 1'b1;
    end else if (io.sc_done_i) begin
      sc_pending_q <= 1'b0;
    end
  end

  // Flush drops ready, so a request presented in a flush cycle never raises a pulse.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      illegal_q   <= 1'b0;
      misalign_q  <= 1'b0;
      exc_vaddr_q <= '0;
    end else begin
      illegal_q  <= accept & illegal;
      misalign_q <= accept & misalign;
      if (accept & (illegal | misalign)) exc_vaddr_q <= io.lsu_vaddr_i;
    end
  end

  assign io.dcache_pkt_v_o = fifo_v;
  assign io.dcache_pkt_o   = fifo_v ? fifo_data_lo : '0;
  assign io.illegal_v_o    = illegal_q;
  assign io.misalign_v_o   = misalign_q;
  assign io.exc_vaddr_o    = exc_vaddr_q;

endmodule

// File: tb/tb_bp_be_dcache_req_encoder.sv
// Purpose: directed self-checking bench for bp_be_dcache_req_encoder.
// Latency: inputs driven 1 time unit after the rising edge; outputs sampled there as well.
// Backpressure: dcache_pkt_ready_i driven per scenario to fill and drain the queue.
module tb_bp_be_dcache_req_encoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bp_be_dcache_req_encoder_if io ();

  bp_be_dcache_req_encoder dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .io       (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    io.lsu_v_i      = 1'b0;
    io.lsu_store_i  = 1'b0;
    io.lsu_signed_i = 1'b0;
    io.lsu_size_i   = 2'd0;
    io.lsu_lr_i     = 1'b0;
    io.lsu_sc_i     = 1'b0;
    io.lsu_vaddr_i  = '0;
    io.lsu_data_i   = '0;
  endtask

  task automatic set_req(input logic st, input logic sg, input logic [1:0] sz,
                         input logic lr, input logic sc,
                         input logic [38:0] va, input logic [63:0] d);
    io.lsu_v_i      = 1'b1;
    io.lsu_store_i  = st;
    io.lsu_signed_i = sg;
    io.lsu_size_i   = sz;
    io.lsu_lr_i     = lr;
    io.lsu_sc_i     = sc;
    io.lsu_vaddr_i  = va;
    io.lsu_data_i   = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_req();
    io.flush_i            = 1'b0;
    io.sc_done_i          = 1'b0;
    io.dcache_pkt_ready_i = 1'b0;
    #12;
    checks++; if (io.dcache_pkt_v_o !== 1'b0) begin errors++; $display("FAIL reset_pkt_v actual=%0h expected=0", io.dcache_pkt_v_o); end
    checks++; if (io.lsu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready actual=%0h expected=0", io.lsu_ready_o); end
    checks++; if (io.misalign_v_o !== 1'b0) begin errors++; $display("FAIL reset_misalign actual=%0h expected=0", io.misalign_v_o); end
    checks++; if (io.illegal_v_o !== 1'b0) begin errors++; $display("FAIL reset_illegal actual=%0h expected=0", io.illegal_v_o); end
    checks++; if (io.exc_vaddr_o !== 39'h0) begin errors++; $display("FAIL reset_exc_vaddr actual=%0h expected=0", io.exc_vaddr_o); end
    checks++; if (io.dcache_pkt_o !== 80'h0) begin errors++; $display("FAIL reset_pkt actual=%0h expected=0", io.dcache_pkt_o); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (io.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready actual=%0h expected=1", io.lsu_ready_o); end
    step();
  endtask

  task automatic test_lw();
    io.dcache_pkt_ready_i = 1'b1;
    set_req(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 39'h1004, 64'h0);
    #1;
    checks++; if (io.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL lw_ready actual=%0h expected=1", io.lsu_ready_o); end
    step();
    idle_req();
    checks++; if (io.dcache_pkt_v_o !== 1'b1) begin errors++; $display("FAIL lw_pkt_v actual=%0h expected=1", io.dcache_pkt_v_o); end
    checks++; if (io.dcache_pkt_o !== {4'b0010, 12'h004, 64'h0}) begin errors++; $display("FAIL lw_pkt actual=%0h expected=%0h", io.dcache_pkt_o, {4'b0010, 12'h004, 64'h0}); end
    step();
    checks++; if (io.dcache_pkt_v_o !== 1'b0) begin errors++; $display("FAIL lw_drained actual=%0h expected=0", io.dcache_pkt_v_o); end
  endtask

  task automatic test_ld_store_repl();
    io.dcache_pkt_ready_i = 1'b1;
    set_req(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 39'h2008, 64'h0);
    step();
    idle_req();
    checks++; if (io.dcache_pkt_o !== {4'b0011, 12'h008, 64'h0}) begin errors++; $display("FAIL ldu_pkt actual=%0h expected=%0h", io.dcache_pkt_o, {4'b0011, 12'h008, 64'h0}); end
    // enqueue while the single queued packet leaves
    set_req(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 39'h4005, 64'h0123_4567_89AB_CDAB);
    step();
    checks++; if (io.dcache_pkt_o !== {4'b1000, 12'h005, 64'hABAB_ABAB_ABAB_ABAB}) begin errors++; $display("FAIL sb_pkt actual=%0h expected=%0h", io.dcache_pkt_o, {4'b1000, 12'h005, 64'hABAB_ABAB_ABAB_ABAB}); end
    set_req(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 39'h4006, 64'h1111_2222_3333_BEEF);
    step();
    idle_req();
    checks++; if (io.dcache_pkt_o !== {4'b1001, 12'h006, 64'hBEEF_BEEF_BEEF_BEEF}) begin errors++; $display("FAIL sh_pkt actual=%0h expected=%0h", io.dcache_pkt_o, {4'b1001, 12'h006, 64'hBEEF_BEEF_BEEF_BEEF}); end
    step();
    checks++; if (io.dcache_pkt_v_o !== 1'b0) begin errors++; $display("FAIL store_drained actual=%0h expected=0", io.dcache_pkt_v_o); end
  endtask

  task automatic test_misalign();
    io.dcache_pkt_ready_i = 1'b1;
    set_req(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 39'h1001, 64'h0);
    step();
    idle_req();
`ifdef BP_BE_DCACHE_REQ_MISALIGN_CHECK_EN
    checks++; if (io.misalign_v_o !== 1'b1) begin errors++; $display("FAIL mis_pulse actual=%0h expected=1", io.misalign_v_o); end
    checks++; if (io.illegal_v_o !== 1'b0) begin errors++; $display("FAIL mis_illegal actual=%0h expected=0", io.illegal_v_o); end
    checks++; if (io.exc_vaddr_o !== 39'h1001) begin errors++; $display("FAIL mis_vaddr actual=%0h expected=1001", io.exc_vaddr_o); end
    checks++; if (io.dcache_pkt_v_o !== 1'b0) begin errors++; $display("FAIL mis_not_issued actual=%0h expected=0", io.dcache_pkt_v_o); end
    step();
    checks++; if (io.misalign_v_o !== 1'b0) begin errors++; $display("FAIL mis_one_cycle actual=%0h expected=0", io.misalign_v_o); end
`else
    checks++; if (io.misalign_v_o !== 1'b0) begin errors++; $display("FAIL mis_off_pulse actual=%0h expected=0", io.misalign_v_o); end
    checks++; if (io.dcache_pkt_o !== {4'b0001, 12'h001, 64'h0}) begin errors++; $display("FAIL mis_off_pkt actual=%0h expected=%0h", io.dcache_pkt_o, {4'b0001, 12'h001, 64'h0}); end
    step();
    checks++; if (io.dcache_pkt_v_o !== 1'b0) begin errors++; $display("FAIL mis_off_drained actual=%0h expected=0", io.dcache_pkt_v_o); end
`endif
  endtask

  task automatic test_back_to_back();
    io.dcache_pkt_ready_i = 1'b0;
    set_req(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 39'h10, 64'h0);
    #1;
    checks++; if (io.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready0 actual=%0h expected=1", io.lsu_ready_o); end
    step();
    set_req(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 39'h12, 64'h0);
    #1;
    checks++; if (io.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready1 actual=%0h expected=1", io.lsu_ready_o); end
    step();
    set_req(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 39'h14, 64'h0);
    #1;
    checks++; if (io.lsu_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full_ready actual=%0h expected=0", io.lsu_ready_o); end
    step();
    checks++; if (io.dcache_pkt_o !== {4'b0100, 12'h010, 64'h0}) begin errors++; $display("FAIL b2b_head_a actual=%0h expected=%0h", io.dcache_pkt_o, {4'b0100, 12'h010, 64'h0}); end
    io.dcache_pkt_ready_i = 1'b1;
    #1;
    checks++; if (io.lsu_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_still_full actual=%0h expected=0", io.lsu_ready_o); end
    step();
    checks++; if (io.dcache_pkt_o !== {4'b0101, 12'h012, 64'h0}) begin errors++; $display("FAIL b2b_head_b actual=%0h expected=%0h", io.dcache_pkt_o, {4'b0101, 12'h012, 64'h0}); end
    checks++; if (io.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_deq actual=%0h expected=1", io.lsu_ready_o); end
    step();
    idle_req();
    checks++; if (io.dcache_pkt_o !== {4'b0110, 12'h014, 64'h0}) begin errors++; $display("FAIL b2b_head_c actual=%0h expected=%0h", io.dcache_pkt_o, {4'b0110, 12'h014, 64'h0}); end
    step();
    checks++; if (io.dcache_pkt_v_o !== 1'b0) begin errors++; $display("FAIL b2b_drained actual=%0h expected=0", io.dcache_pkt_v_o); end
  endtask

  task automatic test_sc();
    io.dcache_pkt_ready_i = 1'b1;
    set_req(1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 39'h3000, 64'h1122_3344_5566_7788);
    #1;
    checks++; if (io.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL scd_ready actual=%0h expected=1", io.lsu_ready_o); end
    step();
    idle_req();
    checks++; if (io.dcache_pkt_o !== {4'b1110, 12'h000, 64'h1122_3344_5566_7788}) begin errors++; $display("FAIL scd_pkt actual=%0h expected=%0h", io.dcache_pkt_o, {4'b1110, 12'h000, 64'h1122_3344_5566_7788}); end
    checks++; if (io.lsu_ready_o !== 1'b0) begin errors++; $display("FAIL scd_hold actual=%0h expected=0", io.lsu_ready_o); end
    step();
    checks++; if (io.lsu_ready_o !== 1'b0) begin errors++; $display("FAIL scd_hold2 actual=%0h expected=0", io.lsu_ready_o); end
    io.sc_done_i = 1'b1;
    step();
    io.sc_done_i = 1'b0;
    #1;
    checks++; if (io.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL scd_release actual=%0h expected=1", io.lsu_ready_o); end
    set_req(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 39'h5008, 64'h0);
    step();
    idle_req();
    checks++; if (io.dcache_pkt_o !== {4'b0010, 12'h008, 64'h0}) begin errors++; $display("FAIL after_sc_pkt actual=%0h expected=%0h", io.dcache_pkt_o, {4'b0010, 12'h008, 64'h0}); end
    step();
  endtask

  task automatic test_illegal();
    io.dcache_pkt_ready_i = 1'b1;
    set_req(1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 39'h6002, 64'h0);
    step();
    idle_req();
    checks++; if (io.illegal_v_o !== 1'b1) begin errors++; $display("FAIL lrh_illegal actual=%0h expected=1", io.illegal_v_o); end
    checks++; if (io.exc_vaddr_o !== 39'h6002) begin errors++; $display("FAIL lrh_vaddr actual=%0h expected=6002", io.exc_vaddr_o); end
    checks++; if (io.dcache_pkt_v_o !== 1'b0) begin errors++; $display("FAIL lrh_not_issued actual=%0h expected=0", io.dcache_pkt_v_o); end
    step();
    checks++; if (io.illegal_v_o !== 1'b0) begin errors++; $display("FAIL lrh_one_cycle actual=%0h expected=0", io.illegal_v_o); end
    set_req(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 39'h7004, 64'h0);
    step();
    checks++; if (io.dcache_pkt_o !== {4'b0111, 12'h004, 64'h0}) begin errors++; $display("FAIL lrw_pkt actual=%0h expected=%0h", io.dcache_pkt_o, {4'b0111, 12'h004, 64'h0}); end
    set_req(1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 39'h7010, 64'h0);
    step();
    idle_req();
    checks++; if (io.illegal_v_o !== 1'b1) begin errors++; $display("FAIL sc_load_illegal actual=%0h expected=1", io.illegal_v_o); end
    checks++; if (io.exc_vaddr_o !== 39'h7010) begin errors++; $display("FAIL sc_load_vaddr actual=%0h expected=7010", io.exc_vaddr_o); end
    checks++; if (io.dcache_pkt_v_o !== 1'b0) begin errors++; $display("FAIL sc_load_not_issued actual=%0h expected=0", io.dcache_pkt_v_o); end
    step();
  endtask

  task automatic test_flush();
    io.dcache_pkt_ready_i = 1'b0;
    set_req(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 39'h20, 64'h0);
    step();
    set_req(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 39'h21, 64'h0);
    step();
    idle_req();
    checks++; if (io.dcache_pkt_v_o !== 1'b1) begin errors++; $display("FAIL flush_queued actual=%0h expected=1", io.dcache_pkt_v_o); end
    io.flush_i = 1'b1;
    set_req(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 39'h8000, 64'h0);
    #1;
    checks++; if (io.lsu_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready actual=%0h expected=0", io.lsu_ready_o); end
    step();
    io.flush_i = 1'b0;
    idle_req();
    #1;
    checks++; if (io.dcache_pkt_v_o !== 1'b0) begin errors++; $display("FAIL flush_pkt_v actual=%0h expected=0", io.dcache_pkt_v_o); end
    checks++; if (io.illegal_v_o !== 1'b0) begin errors++; $display("FAIL flush_illegal_dropped actual=%0h expected=0", io.illegal_v_o); end
    checks++; if (io.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready_after actual=%0h expected=1", io.lsu_ready_o); end
    io.dcache_pkt_ready_i = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_ld_store_repl();
    test_misalign();
    test_back_to_back();
    test_sc();
    test_illegal();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
